// File: rtl/hsp_ram_pkg.sv
// rtl/hsp_ram_pkg.sv - shared types and constants for the RAM port arbiter
//   state_t     : arbiter FSM states
//   LATENCY_MAX : largest supported extra wait per access
//   CNT_W       : width of the access wait counter
//   idx_width() : index width for n entries, never below 1
package hsp_ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int LATENCY_MAX = 15;
   localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// rtl/ram_port_arbiter_rr.sv - round-robin grant selection
//   pending   in  N_CH  channels with an outstanding request
//   ptr       in  IW    highest-priority channel for this arbitration
//   grant     out N_CH  one-hot grant, all zero when nothing is pending
//   grant_idx out IW    index of the granted channel
module rr_arbiter
   import hsp_ram_pkg::*;
#(
   parameter int N_CH = 2
) (
   input  logic [N_CH-1:0]                pending,
   input  logic [idx_width(N_CH)-1:0]     ptr,
   output logic [N_CH-1:0]                grant,
   output logic [idx_width(N_CH)-1:0]     grant_idx
);

   localparam int IW = idx_width(N_CH);

   logic          found;
   int            cand;
   logic [IW-1:0] cand_idx;

   // Scan from ptr upward, wrapping at N_CH; the first pending channel wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_CH) cand = cand - N_CH;
         cand_idx = IW'(cand);
         if (!found && pending[cand_idx]) begin
            found     = 1'b1;
            grant_idx = cand_idx;
         end
      end
      if (found) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - N-channel round-robin arbiter in front of a single-port RAM
//   clk    in  1        system clock
//   rst_l  in  1        synchronous active-low reset
//   req_rd in  N_CH     per-channel read request, held until rdy
//   req_wr in  N_CH     per-channel write request, held until rdy
//   addr   in  N_CH*AW  per-channel address, channel i at [i*AW +: AW]
//   wdata  in  N_CH*DW  per-channel write data, channel i at [i*DW +: DW]
//   rdy    out N_CH     one-cycle completion pulse for the granted channel
//   rdata  out DW       read data while rdy is high, else 0
//   err    out 1        out-of-range address, coincident with rdy
//   busy   out 1        FSM not idle
module ram_port_arbiter
   import hsp_ram_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst_l,
   input  logic [N_CH-1:0]     req_rd,
   input  logic [N_CH-1:0]     req_wr,
   input  logic [N_CH*AW-1:0]  addr,
   input  logic [N_CH*DW-1:0]  wdata,
   output logic [N_CH-1:0]     rdy,
   output logic [DW-1:0]       rdata,
   output logic                err,
   output logic                busy
);

   localparam int           IW        = idx_width(N_CH);
   localparam int           MW        = idx_width(DEPTH);
   localparam logic [AW:0]  DEPTH_EXT = (AW+1)'(DEPTH);

   state_t            state, state_nxt;
   logic [IW-1:0]     ptr;
   logic [CNT_W-1:0]  cnt;
   logic [IW-1:0]     gnt_idx_q;
   logic [N_CH-1:0]   gnt_oh_q;
   logic              op_wr_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     wdata_q;
   logic [DW-1:0]     rdata_q;
   logic              err_q;

   logic [N_CH-1:0]   pending;
   logic [N_CH-1:0]   arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic              sel_wr;
   logic              in_range;
   logic              access_now;
   logic              mem_we;
   logic [MW-1:0]     mem_idx;

   logic [DW-1:0]     mem [DEPTH];

   assign pending = req_rd | req_wr;

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .pending   (pending),
      .ptr       (ptr),
      .grant     (arb_gnt),
      .grant_idx (arb_idx)
   );

   // Operand mux for the granted channel; a write wins over a read on the same channel.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wr    = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (arb_gnt[i]) begin
            sel_addr  = addr[i*AW +: AW];
            sel_wdata = wdata[i*DW +: DW];
            sel_wr    = req_wr[i];
         end
      end
   end

   assign in_range   = ({1'b0, addr_q} < DEPTH_EXT);
   assign mem_idx    = addr_q[MW-1:0];
   assign access_now = (state == ST_ACCESS) && (cnt == '0);
   // Gating with rst_l keeps an access aborted by reset from touching memory.
   assign mem_we     = rst_l && access_now && op_wr_q && in_range;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      rdy       = '0;
      err       = 1'b0;
      rdata     = '0;
      case (state)
         ST_IDLE: begin
            if (|pending) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            rdy       = gnt_oh_q;
            err       = err_q;
            rdata     = rdata_q;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         cnt       <= '0;
         gnt_idx_q <= '0;
         gnt_oh_q  <= '0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (|pending) begin
                  gnt_idx_q <= arb_idx;
                  gnt_oh_q  <= arb_gnt;
                  op_wr_q   <= sel_wr;
                  addr_q    <= sel_addr;
                  wdata_q   <= sel_wdata;
                  cnt       <= CNT_W'(LATENCY);
               end
            end
            ST_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  err_q   <= !in_range;
                  rdata_q <= (in_range && !op_wr_q) ? mem[mem_idx] : '0;
               end
            end
            ST_DONE: begin
               ptr     <= (gnt_idx_q == IW'(N_CH - 1)) ? '0 : gnt_idx_q + IW'(1);
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= wdata_q;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

   localparam int N_CH    = 3;
   localparam int AW      = 16;
   localparam int DW      = 8;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 1;

   logic                clk = 1'b0;
   logic                rst_l = 1'b0;
   logic [N_CH-1:0]     req_rd = '0;
   logic [N_CH-1:0]     req_wr = '0;
   logic [N_CH*AW-1:0]  addr = '0;
   logic [N_CH*DW-1:0]  wdata = '0;
   logic [N_CH-1:0]     rdy;
   logic [DW-1:0]       rdata;
   logic                err;
   logic                busy;

   ram_port_arbiter #(
      .N_CH(N_CH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .LATENCY(LATENCY)
   ) dut (
      .clk(clk), .rst_l(rst_l), .req_rd(req_rd), .req_wr(req_wr),
      .addr(addr), .wdata(wdata), .rdy(rdy), .rdata(rdata), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
      logic          e;
      int            c;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push(input int ch, input logic [DW-1:0] d, input logic e, input int c);
      exp_t x;
      x.ch = ch; x.data = d; x.e = e; x.c = c;
      exp_q.push_back(x);
   endtask

   // Monitor: every rdy pulse consumes one expected completion.
   always @(negedge clk) begin
      exp_t x;
      if (rst_l && rdy != '0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rdy: got rdy=%b expected none", rdy);
         end else begin
            x = exp_q.pop_front();
            check("rdy_vec",   32'(rdy),   32'(1 << x.ch));
            check("rdata",     32'(rdata), 32'(x.data));
            check("err",       32'(err),   32'(x.e));
            check("rdy_cycle", 32'(cyc),   32'(x.c));
         end
      end
   end

   task automatic set_req(input int ch, input bit wr, input bit rd,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr[ch*AW +: AW]  = a;
      wdata[ch*DW +: DW] = d;
      req_wr[ch] = wr;
      req_rd[ch] = rd;
   endtask

   task automatic wait_rdy(input int ch);
      bit got = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rdy[ch]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL rdy_timeout: got no rdy on ch%0d expected a pulse", ch);
      end
   endtask

   task automatic single(input int ch, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input logic exp_e);
      @(posedge clk); #1;
      push(ch, exp_d, exp_e, cyc + LATENCY + 2);
      set_req(ch, wr, !wr, a, d);
      wait_rdy(ch);
      @(posedge clk); #1;
      req_wr[ch] = 1'b0;
      req_rd[ch] = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_l  = 1'b0;
      req_rd = '0;
      req_wr = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_rdy",   32'(rdy),   32'd0);
      check("rst_err",   32'(err),   32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      @(posedge clk); #1;
      rst_l = 1'b1;
   endtask

   logic [DW-1:0] rd_data [N_CH];
   int base;

   initial begin
      rd_data[0] = 8'hA5;
      rd_data[1] = 8'h5A;
      rd_data[2] = 8'hC3;

      // reset state and idle behaviour
      do_reset();
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rdy",  32'(rdy),  32'd0);

      // write then read on ch0, with busy tracking
      @(posedge clk); #1;
      push(0, 8'h00, 1'b0, cyc + LATENCY + 2);
      set_req(0, 1'b1, 1'b0, 16'h0010, 8'hA5);
      @(negedge clk);
      check("busy_before_sample", 32'(busy), 32'd0);
      @(negedge clk);
      check("busy_in_access", 32'(busy), 32'd1);
      wait_rdy(0);
      @(posedge clk); #1;
      req_wr[0] = 1'b0;
      single(0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0);

      // preload for later reads
      single(1, 1'b1, 16'h0011, 8'h5A, 8'h00, 1'b0);
      single(2, 1'b1, 16'h0012, 8'hC3, 8'h00, 1'b0);
      single(0, 1'b1, 16'h0000, 8'h11, 8'h00, 1'b0);
      single(0, 1'b1, 16'h0005, 8'h42, 8'h00, 1'b0);

      // simultaneous reads from reset: ch0 first, ch1 LATENCY+3 later
      do_reset();
      @(posedge clk); #1;
      push(0, 8'hA5, 1'b0, cyc + LATENCY + 2);
      push(1, 8'h5A, 1'b0, cyc + 2*LATENCY + 5);
      set_req(0, 1'b0, 1'b1, 16'h0010, 8'h00);
      set_req(1, 1'b0, 1'b1, 16'h0011, 8'h00);
      fork
         begin wait_rdy(0); @(posedge clk); #1; req_rd[0] = 1'b0; end
         begin wait_rdy(1); @(posedge clk); #1; req_rd[1] = 1'b0; end
      join

      // all channels continuously requesting: order 0,1,2,0,1,2
      do_reset();
      @(posedge clk); #1;
      base = cyc;
      for (int j = 0; j < 2*N_CH; j++)
         push(j % N_CH, rd_data[j % N_CH], 1'b0, base + LATENCY + 2 + j*(LATENCY + 3));
      set_req(0, 1'b0, 1'b1, 16'h0010, 8'h00);
      set_req(1, 1'b0, 1'b1, 16'h0011, 8'h00);
      set_req(2, 1'b0, 1'b1, 16'h0012, 8'h00);
      for (int c = 0; c < N_CH; c++) begin
         fork
            automatic int cc = c;
            begin
               repeat (2) wait_rdy(cc);
               @(posedge clk); #1;
               req_rd[cc] = 1'b0;
            end
         join_none
      end
      wait fork;

      // out-of-range accesses and the last in-range word
      single(2, 1'b0, 16'd1024, 8'h00, 8'h00, 1'b1);
      single(0, 1'b1, 16'd1024, 8'hEE, 8'h00, 1'b1);
      single(1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1);
      single(0, 1'b0, 16'h0000, 8'h00, 8'h11, 1'b0);
      single(1, 1'b1, 16'd1023, 8'h99, 8'h00, 1'b0);
      single(2, 1'b0, 16'd1023, 8'h00, 8'h99, 1'b0);

      // read and write together on ch1: write first, then the read
      @(posedge clk); #1;
      push(1, 8'h00, 1'b0, cyc + LATENCY + 2);
      push(1, 8'h3C, 1'b0, cyc + 2*LATENCY + 5);
      set_req(1, 1'b1, 1'b1, 16'h0020, 8'h3C);
      wait_rdy(1);
      @(posedge clk); #1;
      req_wr[1] = 1'b0;
      wait_rdy(1);
      @(posedge clk); #1;
      req_rd[1] = 1'b0;

      // operands changed during ACCESS are ignored
      @(posedge clk); #1;
      push(0, 8'h00, 1'b0, cyc + LATENCY + 2);
      set_req(0, 1'b1, 1'b0, 16'h0030, 8'h66);
      @(posedge clk); #1;
      addr[0 +: AW]  = 16'h0031;
      wdata[0 +: DW] = 8'h00;
      wait_rdy(0);
      @(posedge clk); #1;
      req_wr[0] = 1'b0;
      single(0, 1'b0, 16'h0030, 8'h00, 8'h66, 1'b0);

      // reset one cycle into ACCESS aborts the write
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 16'h0005, 8'h77);
      @(posedge clk); #1;
      rst_l     = 1'b0;
      req_wr[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdy",  32'(rdy),  32'd0);
      @(posedge clk); #1;
      rst_l = 1'b1;
      single(0, 1'b0, 16'h0005, 8'h00, 8'h42, 1'b0);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
